// File: rtl/sr_pkg.sv
// Shared types and the per-channel next-state resolution for the SR latch bank.
package sr_pkg;

    // What a channel does when set and reset are both asserted.
    typedef enum logic [1:0] {
        SR_SET_PRIO   = 2'd0,
        SR_RESET_PRIO = 2'd1,
        SR_HOLD       = 2'd2,
        SR_TOGGLE     = 2'd3
    } sr_mode_e;

    // Next q for one channel given its synchronised set/reset and current q.
    function automatic logic resolve(
        input sr_mode_e mode,
        input logic     s,
        input logic     r,
        input logic     q
    );
        logic nxt;
        nxt = q;
        case ({s, r})
            2'b00:   nxt = q;
            2'b10:   nxt = 1'b1;
            2'b01:   nxt = 1'b0;
            default: begin
                case (mode)
                    SR_SET_PRIO:   nxt = 1'b1;
                    SR_RESET_PRIO: nxt = 1'b0;
                    SR_HOLD:       nxt = q;
                    SR_TOGGLE:     nxt = ~q;
                    default:       nxt = q;
                endcase
            end
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sr_sync.sv
// Parametrised-depth, parametrised-width flop-chain synchroniser.
// DEPTH=0 passes the input straight through so the consumer registers it directly.
module sr_sync #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign o_q = i_d;
        end else begin : g_chain
            logic [WIDTH-1:0] r_stage [DEPTH];

            // Shift the asynchronous input through DEPTH flops; all stages clear on reset.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
                end else begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/sr_latch_bank.sv
// Bank of independent clocked SR channels with synchronised inputs,
// per-channel sticky conflict flags and a saturating conflict-cycle counter.
module sr_latch_bank
    import sr_pkg::*;
#(
    parameter int                  CHANNELS    = 8,
    parameter sr_mode_e            MODE        = SR_SET_PRIO,
    parameter int                  SYNC_STAGES = 2,
    parameter int                  CNT_WIDTH   = 8,
    parameter logic [CHANNELS-1:0] RESET_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CHANNELS-1:0]  set,
    input  logic [CHANNELS-1:0]  reset,
    input  logic                 clear_conflict,
    output logic [CHANNELS-1:0]  q,
    output logic [CHANNELS-1:0]  q_not,
    output logic [CHANNELS-1:0]  conflict_sticky,
    output logic [CNT_WIDTH-1:0] conflict_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CHANNELS-1:0]  w_s_sync;
    logic [CHANNELS-1:0]  w_r_sync;
    logic [CHANNELS-1:0]  w_q_next;
    logic [CHANNELS-1:0]  w_conflict;
    logic                 w_any_conflict;
    logic [CHANNELS-1:0]  r_q;
    logic [CHANNELS-1:0]  r_sticky;
    logic [CNT_WIDTH-1:0] r_count;

    sr_sync #(.DEPTH(SYNC_STAGES), .WIDTH(CHANNELS)) u_sync_set (
        .clk (clk),
        .rst (rst),
        .i_d (set),
        .o_q (w_s_sync)
    );

    sr_sync #(.DEPTH(SYNC_STAGES), .WIDTH(CHANNELS)) u_sync_reset (
        .clk (clk),
        .rst (rst),
        .i_d (reset),
        .o_q (w_r_sync)
    );

    assign w_conflict     = w_s_sync & w_r_sync;
    assign w_any_conflict = |w_conflict;

    // Resolve each channel's next state independently from its own synchronised inputs.
    always_comb begin
        w_q_next = r_q;
        for (int i = 0; i < CHANNELS; i++) begin
            w_q_next[i] = resolve(MODE, w_s_sync[i], w_r_sync[i], r_q[i]);
        end
    end

    // Channel state register; clear_conflict deliberately has no effect here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_q <= RESET_VALUE;
        else     r_q <= w_q_next;
    end

    // Sticky conflict flags; a clear in the same cycle as a new conflict drops the conflict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 r_sticky <= '0;
        else if (clear_conflict) r_sticky <= '0;
        else                     r_sticky <= r_sticky | w_conflict;
    end

    // Count cycles with any conflict, saturating at all-ones; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                      r_count <= '0;
        else if (clear_conflict)                      r_count <= '0;
        else if (w_any_conflict && r_count != CNT_MAX) r_count <= r_count + CNT_ONE;
    end

    // q_not is derived combinationally so it is the exact complement even during reset.
    assign q               = r_q;
    assign q_not           = ~r_q;
    assign conflict_sticky = r_sticky;
    assign conflict_count  = r_count;

endmodule

// File: tb/tb_sr_latch_bank.sv
// Bench for sr_latch_bank: four instances (one per resolution mode) share stimulus;
// expectations are queued with the cycle they fall due and a monitor checks them.
`timescale 1ns/1ps
module tb_sr_latch_bank;
    import sr_pkg::*;

    localparam int         CH = 4;
    localparam int         CW = 3;
    localparam logic [3:0] RV = 4'b1010;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] set_i = '0;
    logic [3:0] reset_i = '0;
    logic       clr = 1'b0;

    logic [3:0]    q_o   [4];
    logic [3:0]    qn_o  [4];
    logic [3:0]    st_o  [4];
    logic [CW-1:0] cnt_o [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sr_latch_bank #(
            .CHANNELS(CH), .MODE(sr_mode_e'(g)), .SYNC_STAGES(2),
            .CNT_WIDTH(CW), .RESET_VALUE(RV)
        ) u_dut (
            .clk(clk), .rst(rst), .set(set_i), .reset(reset_i),
            .clear_conflict(clr), .q(q_o[g]), .q_not(qn_o[g]),
            .conflict_sticky(st_o[g]), .conflict_count(cnt_o[g])
        );
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        int         dut;
        int         fld;   // 0=q 1=sticky 2=count
        logic [7:0] exp;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input int dut, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d (mode %0d) cyc %0d: got %b expected %b", nm, dut, dut, cyc, act, exp);
    endtask

    function automatic logic [7:0] act_of(input int dut, input int fld);
        case (fld)
            0:       return {4'b0, q_o[dut]};
            1:       return {4'b0, st_o[dut]};
            default: return {5'b0, cnt_o[dut]};
        endcase
    endfunction

    task automatic ex(input int due, input int dut, input int fld, input logic [7:0] v, input string nm);
        exp_t e;
        e.due = due; e.dut = dut; e.fld = fld; e.exp = v; e.nm = nm;
        sb.push_back(e);
    endtask

    // Expected q per mode: set-prio, reset-prio, hold, toggle.
    task automatic exq(input int due, input logic [3:0] v0, input logic [3:0] v1,
                       input logic [3:0] v2, input logic [3:0] v3, input string nm);
        ex(due, 0, 0, {4'b0, v0}, nm);
        ex(due, 1, 0, {4'b0, v1}, nm);
        ex(due, 2, 0, {4'b0, v2}, nm);
        ex(due, 3, 0, {4'b0, v3}, nm);
    endtask

    // Conflict status is mode-independent, so expect the same in every instance.
    task automatic exc(input int due, input logic [7:0] cnt, input logic [3:0] st, input string nm);
        for (int d = 0; d < 4; d++) begin
            ex(due, d, 2, cnt, {nm, "_cnt"});
            ex(due, d, 1, {4'b0, st}, {nm, "_sticky"});
        end
    endtask

    task automatic go(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_state(input string nm);
        for (int d = 0; d < 4; d++) begin
            chk({nm, "_q"},      d, {4'b0, q_o[d]},  {4'b0, RV});
            chk({nm, "_qn"},     d, {4'b0, qn_o[d]}, {4'b0, ~RV});
            chk({nm, "_cnt"},    d, {5'b0, cnt_o[d]}, 8'd0);
            chk({nm, "_sticky"}, d, {4'b0, st_o[d]}, 8'd0);
        end
    endtask

    // Monitor: q_not invariant every cycle, then retire expectations that are due.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 4; d++)
                chk("q_not_inv", d, {4'b0, qn_o[d]}, {4'b0, ~q_o[d]});
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                chk(e.nm, e.dut, act_of(e.dut, e.fld), e.exp);
            end
        end
    end

    initial begin
        int k;
        int bound;
        // Reset takes effect with no clock edge.
        #1 rst = 1'b1;
        #1 chk_reset_state("rst_async");
        go(2);
        rst = 1'b0;

        // One-cycle set pulse on channel 0: q[0] rises exactly 3 edges later.
        go(1); k = cyc; set_i = 4'b0001;
        exq(k+2, RV, RV, RV, RV, "lat_set_early");
        exq(k+3, 4'b1011, 4'b1011, 4'b1011, 4'b1011, "lat_set");
        go(1); set_i = '0; go(3);
        k = cyc; reset_i = 4'b0001;
        exq(k+2, 4'b1011, 4'b1011, 4'b1011, 4'b1011, "lat_rst_early");
        exq(k+3, RV, RV, RV, RV, "lat_rst");
        go(1); reset_i = '0; go(3);
        // Bring q[1] to 0 ahead of the mode test.
        k = cyc; reset_i = 4'b0010;
        exq(k+3, 4'b1000, 4'b1000, 4'b1000, 4'b1000, "q1_clear");
        go(1); reset_i = '0; go(3);

        // Conflict on channel 1 held for 4 cycles, per-mode resolution.
        k = cyc; set_i = 4'b0010; reset_i = 4'b0010;
        exc(k+2, 8'd0, 4'b0000, "mode_pre");
        exq(k+3, 4'b1010, 4'b1000, 4'b1000, 4'b1010, "mode_c1");
        exc(k+3, 8'd1, 4'b0010, "mode_c1");
        exq(k+4, 4'b1010, 4'b1000, 4'b1000, 4'b1000, "mode_c2");
        exq(k+5, 4'b1010, 4'b1000, 4'b1000, 4'b1010, "mode_c3");
        exq(k+6, 4'b1010, 4'b1000, 4'b1000, 4'b1000, "mode_c4");
        exc(k+6, 8'd4, 4'b0010, "mode_c4");
        exq(k+7, 4'b1010, 4'b1000, 4'b1000, 4'b1000, "mode_after");
        exc(k+7, 8'd4, 4'b0010, "mode_after");
        go(4); set_i = '0; reset_i = '0; go(4);

        // Clear, then 10 conflict cycles on channels 0 and 3: counter saturates at 7.
        k = cyc; clr = 1'b1;
        exc(k+1, 8'd0, 4'b0000, "clr1");
        go(1); clr = 1'b0; go(1);
        k = cyc; set_i = 4'b1001; reset_i = 4'b1001;
        exq(k+3, 4'b1011, 4'b0000, 4'b1000, 4'b0001, "sat_q_first");
        exc(k+3, 8'd1, 4'b1001, "sat_first");
        exc(k+9, 8'd7, 4'b1001, "sat_reach");
        exc(k+10, 8'd7, 4'b1001, "sat_hold");
        exq(k+13, 4'b1011, 4'b0000, 4'b1000, 4'b1000, "sat_q_end");
        exc(k+13, 8'd7, 4'b1001, "sat_end");
        go(10); set_i = '0; reset_i = '0; go(4);
        // Clear does not disturb q.
        k = cyc; clr = 1'b1;
        exq(k+1, 4'b1011, 4'b0000, 4'b1000, 4'b1000, "clr2_q");
        exc(k+1, 8'd0, 4'b0000, "clr2");
        go(1); clr = 1'b0; go(1);

        // Clear coincides with the first synchronised conflict on channel 2: clear wins.
        k = cyc; set_i = 4'b0100; reset_i = 4'b0100;
        go(2); clr = 1'b1;
        exc(k+3, 8'd0, 4'b0000, "clr_win");
        exq(k+4, 4'b1111, 4'b0000, 4'b1000, 4'b1000, "clr_win_q");
        exc(k+4, 8'd1, 4'b0100, "clr_after");
        go(1); clr = 1'b0; go(4);

        // Asynchronous reset mid-toggle on channel 2: all in-flight state discarded.
        #2 rst = 1'b1;
        #1 chk_reset_state("rst_mid");
        set_i = '0; reset_i = '0;
        go(2); rst = 1'b0;
        k = cyc;
        exq(k+4, RV, RV, RV, RV, "post_rst_q");
        exc(k+4, 8'd0, 4'b0000, "post_rst");
        go(6);

        bound = 0;
        while (sb.size() > 0 && bound < 20) begin
            go(1);
            bound++;
        end
        if (sb.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations still pending, required 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
